// File: rtl/mmu_acc_ctrl.sv
// Feed/drain sequencer for the matrix multiply unit's accumulate load counter.
// Optional write statistics port enabled by defining MMU_ACC_CTRL_STATS_EN.
module mmu_acc_ctrl #(
  parameter int unsigned MATRIX_WIDTH   = 14,
  parameter int unsigned ACC_ADDR_WIDTH = 16,
  parameter int unsigned LENGTH_WIDTH   = 32,
  parameter int unsigned RESULT_LATENCY = 2*MATRIX_WIDTH+2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      instr_valid,
  input  logic [ACC_ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [LENGTH_WIDTH-1:0]   instr_length,
  input  logic                      instr_accumulate,
  output logic                      busy,
  output logic                      mmu_feed,
  output logic                      ctr_load,
  output logic [ACC_ADDR_WIDTH-1:0] ctr_start_val,
  output logic                      ctr_enable,
  output logic                      acc_wr_en,
  output logic                      acc_accumulate,
  output logic                      done
`ifdef MMU_ACC_CTRL_STATS_EN
  ,
  output logic [31:0]               wr_count
`endif
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, FIN} state_e;

  state_e                    state_q, state_d;
  logic [LENGTH_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      acc_q, acc_d;
  logic                      first_q, first_d;

  // Delay line stages: index 0 is the newest, RESULT_LATENCY-1 the array output.
  logic [RESULT_LATENCY-1:0] vld_q, vacc_q, vfst_q;

  logic feed_raw;
  logic pending;

  assign feed_raw = (state_q == FEED);
  // The last stage is consumed this cycle, so only earlier stages count as pending.
  assign pending  = |vld_q[RESULT_LATENCY-2:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          addr_d  = instr_acc_addr;
          acc_d   = instr_accumulate;
          cnt_d   = instr_length;
          first_d = 1'b1;
          state_d = (instr_length == '0) ? FIN : FEED;
        end
      end
      FEED: begin
        cnt_d   = cnt_q - LENGTH_WIDTH'(1);
        first_d = 1'b0;
        if (cnt_q == LENGTH_WIDTH'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pending) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      acc_q   <= 1'b0;
      first_q <= 1'b0;
      vld_q   <= '0;
      vacc_q  <= '0;
      vfst_q  <= '0;
    end else if (enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      vld_q   <= {vld_q[RESULT_LATENCY-2:0],  feed_raw};
      vacc_q  <= {vacc_q[RESULT_LATENCY-2:0], feed_raw & acc_q};
      vfst_q  <= {vfst_q[RESULT_LATENCY-2:0], feed_raw & first_q};
    end
  end

  assign busy           = (state_q != IDLE);
  assign mmu_feed       = feed_raw & enable;
  assign ctr_load       = vfst_q[RESULT_LATENCY-3] & enable;
  assign ctr_start_val  = addr_q;
  // Union of the last three stages spans exactly first load through last write.
  assign ctr_enable     = (|vld_q[RESULT_LATENCY-1 -: 3]) & enable;
  assign acc_wr_en      = vld_q[RESULT_LATENCY-1] & enable;
  assign acc_accumulate = vacc_q[RESULT_LATENCY-1] & enable;
  assign done           = (state_q == FIN) & enable;

`ifdef MMU_ACC_CTRL_STATS_EN
  logic [31:0] wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (acc_wr_en && (wr_count_q != '1)) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mmu_acc_ctrl.sv
// Self-checking bench for mmu_acc_ctrl: directed vector table, corner sequences,
// and randomized traffic checked against an enabled-cycle event-schedule model.
`timescale 1ns/1ps
module tb_mmu_acc_ctrl;
  localparam int unsigned MW = 14;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 32;
  localparam int          R  = 2*MW+2;

  logic          clk = 1'b0;
  logic          rst, enable, instr_valid, instr_accumulate;
  logic [AW-1:0] instr_acc_addr;
  logic [LW-1:0] instr_length;
  logic          busy, mmu_feed, ctr_load, ctr_enable, acc_wr_en, acc_accumulate, done;
  logic [AW-1:0] ctr_start_val;
`ifdef MMU_ACC_CTRL_STATS_EN
  logic [31:0]   wr_count;
`endif

  mmu_acc_ctrl #(
    .MATRIX_WIDTH(MW),
    .ACC_ADDR_WIDTH(AW),
    .LENGTH_WIDTH(LW),
    .RESULT_LATENCY(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .instr_valid(instr_valid),
    .instr_acc_addr(instr_acc_addr),
    .instr_length(instr_length),
    .instr_accumulate(instr_accumulate),
    .busy(busy),
    .mmu_feed(mmu_feed),
    .ctr_load(ctr_load),
    .ctr_start_val(ctr_start_val),
    .ctr_enable(ctr_enable),
    .acc_wr_en(acc_wr_en),
    .acc_accumulate(acc_accumulate),
    .done(done)
`ifdef MMU_ACC_CTRL_STATS_EN
    ,
    .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one instruction described by its accept time in enabled cycles.
  longint          ecnt  = 0;
  longint          m_ta  = 0;
  longint          m_len = 0;
  bit              m_have = 1'b0;
  bit              m_acc  = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  longint unsigned m_wrc  = 0;
  bit e_busy, e_feed, e_load, e_cen, e_wr, e_acc, e_done;

  logic          s_busy, s_feed, s_load, s_cen, s_wr, s_acc, s_done;
  logic [AW-1:0] s_start;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    bit            acc;
    int            stall_at;
    int            stall_n;
    int            feeds;
    int            wrs;
    int            load_at;
    int            done_at;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic calc_exp();
    longint d;
    d = ecnt - m_ta;
    {e_busy, e_feed, e_load, e_cen, e_wr, e_acc, e_done} = '0;
    if (m_have) begin
      if (m_len == 0) begin
        e_busy = (d == 1);
        e_done = (d == 1);
      end else begin
        e_busy = (d >= 1) && (d <= m_len + R + 1);
        e_feed = (d >= 1) && (d <= m_len);
        e_load = (d == R - 1);
        e_cen  = (d >= R - 1) && (d <= m_len + R);
        e_wr   = (d >= R + 1) && (d <= m_len + R);
        e_acc  = e_wr && m_acc;
        e_done = (d == m_len + R + 1);
      end
    end
    if (!enable) {e_feed, e_load, e_cen, e_wr, e_acc, e_done} = '0;
  endtask

  // One clock: check at negedge, advance model at posedge, release 1ns later.
  task automatic cycle();
    @(negedge clk);
    if (rst) begin
      m_have = 1'b0;
      m_addr = '0;
      m_wrc  = 0;
    end
    calc_exp();
    chk("busy", busy, e_busy);
    chk("mmu_feed", mmu_feed, e_feed);
    chk("ctr_load", ctr_load, e_load);
    chk("ctr_enable", ctr_enable, e_cen);
    chk("acc_wr_en", acc_wr_en, e_wr);
    chk("acc_accumulate", acc_accumulate, e_acc);
    chk("done", done, e_done);
    chk("ctr_start_val", ctr_start_val, m_addr);
`ifdef MMU_ACC_CTRL_STATS_EN
    chk("wr_count", wr_count, m_wrc);
`endif
    s_busy = busy; s_feed = mmu_feed; s_load = ctr_load; s_cen = ctr_enable;
    s_wr = acc_wr_en; s_acc = acc_accumulate; s_done = done; s_start = ctr_start_val;
    @(posedge clk);
    if (!rst && enable) begin
      if (e_wr && m_wrc < 64'hFFFF_FFFF) m_wrc++;
      if (instr_valid && !e_busy) begin
        m_have = 1'b1;
        m_ta   = ecnt;
        m_len  = longint'(instr_length);
        m_addr = instr_acc_addr;
        m_acc  = instr_accumulate;
      end
      ecnt++;
    end
    #1;
  endtask

  task automatic wait_done(input int c0, output int at);
    at = -1;
    for (int c = c0; c < c0 + 120 && at < 0; c++) begin
      cycle();
      if (s_done) at = c;
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input int len, input bit acc);
    instr_valid      = 1'b1;
    instr_acc_addr   = a;
    instr_length     = LW'(len);
    instr_accumulate = acc;
    cycle();
    instr_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int feeds, wrs, accs, load_at, done_at;
    logic [AW-1:0] load_addr;
    feeds = 0; wrs = 0; accs = 0; load_at = -1; done_at = -1; load_addr = '0;
    instr_valid      = 1'b1;
    instr_acc_addr   = v.addr;
    instr_length     = LW'(v.len);
    instr_accumulate = v.acc;
    for (int c = 0; c < 100 && done_at < 0; c++) begin
      enable = !(v.stall_n > 0 && c >= v.stall_at && c < v.stall_at + v.stall_n);
      cycle();
      if (c == 0) instr_valid = 1'b0;
      if (s_feed) feeds++;
      if (s_wr) wrs++;
      if (s_acc) accs++;
      if (s_load && load_at < 0) begin
        load_at   = c;
        load_addr = s_start;
      end
      if (s_done) done_at = c;
    end
    enable = 1'b1;
    chk("vec feeds", feeds, v.feeds);
    chk("vec writes", wrs, v.wrs);
    chk("vec accumulate", accs, v.acc ? v.wrs : 0);
    chk("vec load cycle", load_at, v.load_at);
    chk("vec done cycle", done_at, v.done_at);
    if (v.len > 0) chk("vec start addr", load_addr, v.addr);
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, cnt;
    //         addr      len acc stall_at stall_n feeds wrs load done
    vt[0] = '{16'h0040, 4, 1'b1, 0,  0, 4, 4, 29, 35};
    vt[1] = '{16'h1234, 0, 1'b1, 0,  0, 0, 0, -1, 1};
    vt[2] = '{16'h0ABC, 3, 1'b0, 2,  2, 3, 3, 31, 36};
    vt[3] = '{16'hFFFF, 1, 1'b1, 0,  0, 1, 1, 29, 32};
    vt[4] = '{16'h0100, 2, 1'b0, 30, 1, 2, 2, 29, 34};
    vt[5] = '{16'h0200, 1, 1'b1, 29, 1, 1, 1, 30, 33};
    vt[6] = '{16'h0300, 5, 1'b1, 1,  5, 5, 5, 34, 41};

    rst = 1'b1; enable = 1'b1; instr_valid = 1'b0; instr_accumulate = 1'b0;
    instr_acc_addr = '0; instr_length = '0;
    #1;
    cycle();
    cycle();
    chk("reset busy", s_busy, 1'b0);
    chk("reset start_val", s_start, '0);
    rst = 1'b0;
    repeat (3) cycle();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Second instruction held valid while the first is in flight.
    issue(16'h0AA0, 1, 1'b1);
    instr_valid = 1'b1; instr_acc_addr = 16'h0BB0; instr_length = LW'(2); instr_accumulate = 1'b0;
    at = -1;
    for (int c = 1; c < 80 && at < 0; c++) begin
      cycle();
      if (!s_busy) at = c;
    end
    instr_valid = 1'b0;
    chk("b2b accept cycle", at, 33);
    wait_done(34, at);
    chk("b2b second done", at, 66);
    cycle();

    // Reset while the instruction is draining.
    issue(16'h0C0C, 4, 1'b1);
    for (int c = 1; c < 20; c++) cycle();
    rst = 1'b1;
    cycle();
    chk("rst mid outputs", {s_busy, s_feed, s_load, s_cen, s_wr, s_acc, s_done}, 7'b0);
    chk("rst mid start_val", s_start, '0);
    cycle();
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      cycle();
      if (s_wr || s_done) cnt++;
    end
    chk("post reset stray pulses", cnt, 0);
    issue(16'h0D0D, 2, 1'b0);
    wait_done(1, at);
    chk("post reset done", at, 33);
    cycle();

`ifdef MMU_ACC_CTRL_STATS_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    issue(16'h0010, 5, 1'b1);
    wait_done(1, at);
    cycle();
    issue(16'h0020, 7, 1'b0);
    wait_done(1, at);
    cycle();
    chk("stats wr_count", wr_count, 32'd12);
`endif

    for (int k = 0; k < 400; k++) begin
      rst              = ($urandom_range(0, 199) == 0);
      enable           = ($urandom_range(0, 9) != 0);
      instr_valid      = ($urandom_range(0, 2) == 0);
      instr_length     = LW'($urandom_range(0, 5));
      instr_acc_addr   = AW'($urandom);
      instr_accumulate = 1'($urandom_range(0, 1));
      cycle();
    end
    rst = 1'b0; enable = 1'b1; instr_valid = 1'b0;
    repeat (40) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
